// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {p,q} left, add or subtract d
// depending on the sign of the old partial remainder, and set the new quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;

  assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  assign d_ext   = {1'b0, d};

  // p[WIDTH] is the sign of the partial remainder before the shift.
  assign p_next = p[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_qshift
      assign q_next[gi] = q[gi-1];
    end
  endgenerate

  assign q_next[0] = ~p_next[WIDTH];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed divider: one non-restoring step per clock, with a
// start/busy/done handshake and results held for the HI/LO registers.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_reg;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] count_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] dividend_reg;

  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_next),
    .q_next (q_next)
  );

  // The most-negative operand maps to 2^(WIDTH-1), which fits as unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // Final restore: a negative partial remainder plus D lands in [0, D).
  assign r_mag    = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + d_reg) : p_reg[WIDTH-1:0];
  assign q_signed = sign_q_reg ? -q_reg : q_reg;
  assign r_signed = sign_r_reg ? -r_mag : r_mag;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg    <= IDLE;
      p_reg        <= '0;
      q_reg        <= '0;
      d_reg        <= '0;
      count_reg    <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      dz_reg       <= 1'b0;
      dividend_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          // done is still high in the cycle after DONE; a start there is dropped.
          if (start && !done) begin
            q_reg        <= dividend_mag;
            d_reg        <= divisor_mag;
            p_reg        <= '0;
            sign_q_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_reg   <= dividend[WIDTH-1];
            dividend_reg <= dividend;
            count_reg    <= CNT_W'(WIDTH - 1);
            div_by_zero  <= 1'b0;
            dz_reg       <= (divisor == '0);
            state_reg    <= (divisor == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          busy  <= 1'b1;
          p_reg <= p_next;
          q_reg <= q_next;
          if (count_reg == '0) begin
            state_reg <= FIX;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
        FIX: begin
          busy <= 1'b1;
          if (dz_reg) begin
            quotient    <= WIDTH'(DZ_QUOTIENT);
            remainder   <= dividend_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_signed;
            remainder   <= r_signed;
            div_by_zero <= 1'b0;
          end
          state_reg <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed scenarios plus a randomized
// signed regression against a plain-arithmetic reference model.
module tb_div_sequencer;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_q, got_r;
  logic         got_dz;
  int           got_lat, got_busy;

  always #5 clock = ~clock;

  div_sequencer #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference: truncating signed division; divide-by-zero returns all ones / dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
    end
  endfunction

  // Issue one operation, scramble operands after accept, wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    if (done) begin
      @(posedge clock); #1;
    end
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    got_lat = -1; got_busy = 0;
    for (int cyc = 1; cyc <= DIV_LATENCY + 10; cyc++) begin
      @(posedge clock); #1;
      if (done) begin
        got_lat = cyc;
        break;
      end
      if (busy) got_busy++;
    end
    got_q = quotient; got_r = remainder; got_dz = div_by_zero;
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d busy=%0d",
             $signed(a), $signed(b), $signed(got_q), $signed(got_r), got_dz, got_lat, got_busy);
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b q=%h r=%h dz=%0b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7);
    checks++; if (got_lat !== DIV_LATENCY) begin errors++; $display("FAIL basic_latency got %0d want %0d", got_lat, DIV_LATENCY); end
    checks++; if (got_busy !== DIV_LATENCY - 1) begin errors++; $display("FAIL basic_busy got %0d want %0d", got_busy, DIV_LATENCY - 1); end
    checks++; if (got_q !== 32'd14) begin errors++; $display("FAIL basic_q got %0d want 14", got_q); end
    checks++; if (got_r !== 32'd2) begin errors++; $display("FAIL basic_r got %0d want 2", got_r); end
    checks++; if (got_dz !== 1'b0) begin errors++; $display("FAIL basic_dz got %0b want 0", got_dz); end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL basic_hold got done=%0b q=%0d r=%0d want 0/14/2", done, quotient, remainder);
    end
  endtask

  task automatic test_signs();
    logic [W-1:0] ta [5] = '{-32'sd100, 32'd100, -32'sd100, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] tb [5] = '{32'd7, -32'sd7, -32'sd7, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] tq [5] = '{-32'sd14, -32'sd14, 32'd14, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] tr [5] = '{-32'sd2, 32'd2, -32'sd2, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i]);
      checks++;
      if (got_q !== tq[i] || got_r !== tr[i] || got_dz !== 1'b0) begin
        errors++;
        $display("FAIL signs_%0d got q=%h r=%h dz=%0b want q=%h r=%h dz=0",
                 i, got_q, got_r, got_dz, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(32'd55, 32'd0);
    checks++; if (got_lat !== 2) begin errors++; $display("FAIL dz_latency got %0d want 2", got_lat); end
    checks++;
    if (got_q !== 32'hFFFF_FFFF || got_r !== 32'd55 || got_dz !== 1'b1) begin
      errors++;
      $display("FAIL dz_result got q=%h r=%0d dz=%0b want ffffffff/55/1", got_q, got_r, got_dz);
    end
    run_op(32'd9, 32'd3);
    checks++;
    if (got_q !== 32'd3 || got_r !== 32'd0 || got_dz !== 1'b0 || got_lat !== DIV_LATENCY) begin
      errors++;
      $display("FAIL dz_clear got q=%0d r=%0d dz=%0b lat=%0d want 3/0/0/%0d",
               got_q, got_r, got_dz, got_lat, DIV_LATENCY);
    end
  endtask

  task automatic test_abort();
    int dones;
    if (done) begin @(posedge clock); #1; end
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%0b done=%0b q=%h r=%h dz=%0b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock); clear = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < DIV_LATENCY + 6; cyc++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
    run_op(32'd1000, 32'd10);
    checks++;
    if (got_q !== 32'd100 || got_r !== 32'd0 || got_lat !== DIV_LATENCY) begin
      errors++;
      $display("FAIL abort_rerun got q=%0d r=%0d lat=%0d want 100/0/%0d", got_q, got_r, got_lat, DIV_LATENCY);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b, eq, er;
    logic edz;
    int dones, lat;
    logic [W-1:0] first_q, first_r;
    a = 32'd12345; b = -32'sd67;
    model(a, b, eq, er, edz);
    if (done) begin @(posedge clock); #1; end
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dones = 0; lat = -1; first_q = '0; first_r = '0;
    for (int cyc = 1; cyc <= DIV_LATENCY + 12; cyc++) begin
      @(posedge clock); #1;
      if (done) begin
        dones++;
        if (lat < 0) begin lat = cyc; first_q = quotient; first_r = remainder; end
      end
      start = (cyc == 5 || cyc == 20);
      dividend = 32'd7; divisor = 32'd2;
    end
    start = 1'b0;
    $display("op ignore-start %0d / %0d -> q=%0d r=%0d lat=%0d dones=%0d",
             $signed(a), $signed(b), $signed(first_q), $signed(first_r), lat, dones);
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    checks++;
    if (first_q !== eq || first_r !== er || lat !== DIV_LATENCY) begin
      errors++;
      $display("FAIL ignore_result got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
               first_q, first_r, lat, eq, er, DIV_LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    int activity;
    run_op(32'd81, 32'd9);
    // A start held only during the done cycle must be dropped.
    dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    activity = 0;
    for (int cyc = 0; cyc < DIV_LATENCY + 4; cyc++) begin
      @(posedge clock); #1;
      if (done || busy) activity++;
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL b2b_done_cycle_start got %0d active cycles want 0", activity); end
    run_op(-32'sd77, 32'd5);
    run_op(32'd64, -32'sd8);
    checks++;
    if (got_q !== -32'sd8 || got_r !== 32'd0 || got_lat !== DIV_LATENCY) begin
      errors++;
      $display("FAIL b2b_second got q=%h r=%h lat=%0d want fffffff8/0/%0d", got_q, got_r, got_lat, DIV_LATENCY);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er, recon;
    logic edz;
    int sel, want_lat;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      a = ($urandom_range(0, 3) == 0) ? W'($signed(32'($urandom_range(0, 2000)) - 32'd1000)) : W'($urandom);
      case (sel)
        0: b = '0;
        1: b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 20)) : -W'($urandom_range(1, 20));
        2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : W'($urandom); end
        default: b = W'($urandom);
      endcase
      model(a, b, eq, er, edz);
      want_lat = (b == '0) ? 2 : DIV_LATENCY;
      run_op(a, b);
      checks++;
      if (got_q !== eq || got_r !== er || got_dz !== edz || got_lat !== want_lat) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h dz=%0b lat=%0d want q=%h r=%h dz=%0b lat=%0d",
                 n, a, b, got_q, got_r, got_dz, got_lat, eq, er, edz, want_lat);
      end
      if (b != '0) begin
        recon = got_q * b + got_r;
        checks++;
        if (recon !== a || (got_r != '0 && got_r[W-1] !== a[W-1])) begin
          errors++;
          $display("FAIL rand_invariant_%0d a=%h b=%h got recon=%h rsign=%0b want recon=%h rsign=%0b",
                   n, a, b, recon, got_r[W-1], a, a[W-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
